// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants and enums for the execute-control slice.
package rv32i_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_PC4  = 2'b01,
        WB_LOAD = 2'b10
    } wb_sel_e;

    // inst[30] only turns ADD into SUB for register-register ops; ADDI ignores it.
    function automatic alu_op_e decode_alu_op(input logic [2:0] f3, input logic alt, input logic is_r);
        case (f3)
            F3_ADD:  return (alt && is_r) ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_exec_ctrl_branch_cmp.sv
// Combinational branch comparator: equality plus signed/unsigned less-than.
module branch_cmp #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_unsigned,
    output logic             o_eq,
    output logic             o_lt
);

    always_comb begin
        o_eq = (i_a == i_b);
        o_lt = i_unsigned ? (i_a < i_b) : ($signed(i_a) < $signed(i_b));
    end

endmodule

// File: rtl/rv32i_exec_ctrl.sv
// RV32I decode + branch compare + ALU with fully registered outputs.
// Optional illegal-encoding output enabled by defining RV32I_ILLEGAL_DET_EN.
module rv32i_exec_ctrl
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] alu_result_o,
    output logic            pc_sel_o,
    output logic            rd_wren_o,
    output logic            mem_wren_o,
    output logic [1:0]      wb_sel_o,
`ifdef RV32I_ILLEGAL_DET_EN
    output logic            illegal_o,
`endif
    output logic [XLEN-1:0] pc_plus4_o
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic            w_alt;
    logic            w_rd_nz;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    alu_op_e         w_alu_op;
    wb_sel_e         w_wb_sel;
    logic            w_rd_wren;
    logic            w_mem_wren;
    logic            w_is_branch;
    logic            w_is_jump;
    logic            w_is_jalr;
    logic            w_eq;
    logic            w_lt;
    logic            w_taken;
    logic [XLEN-1:0] w_alu_raw;
    logic [XLEN-1:0] w_alu_res;
    logic            w_unused;

    assign w_opcode = inst_i[6:0];
    assign w_f3     = inst_i[14:12];
    assign w_f7     = inst_i[31:25];
    assign w_alt    = inst_i[30];
    assign w_rd_nz  = |inst_i[11:7];
    assign w_unused = &{1'b0, inst_i[24:15], w_f7};

    always_comb begin
        w_op1       = rs1_data_i;
        w_op2       = imm_i;
        w_alu_op    = ALU_ADD;
        w_wb_sel    = WB_ALU;
        w_rd_wren   = 1'b0;
        w_mem_wren  = 1'b0;
        w_is_branch = 1'b0;
        w_is_jump   = 1'b0;
        w_is_jalr   = 1'b0;
        case (w_opcode)
            OPC_R: begin
                w_op2     = rs2_data_i;
                w_alu_op  = decode_alu_op(w_f3, w_alt, 1'b1);
                w_rd_wren = 1'b1;
            end
            OPC_I: begin
                w_alu_op  = decode_alu_op(w_f3, w_alt, 1'b0);
                w_rd_wren = 1'b1;
            end
            OPC_LOAD: begin
                w_rd_wren = 1'b1;
                w_wb_sel  = WB_LOAD;
            end
            OPC_STORE: w_mem_wren = 1'b1;
            OPC_BRANCH: begin
                w_op1       = pc_i;
                w_is_branch = 1'b1;
            end
            OPC_JAL: begin
                w_op1     = pc_i;
                w_is_jump = 1'b1;
                w_rd_wren = 1'b1;
                w_wb_sel  = WB_PC4;
            end
            OPC_JALR: begin
                w_is_jump = 1'b1;
                w_is_jalr = 1'b1;
                w_rd_wren = 1'b1;
                w_wb_sel  = WB_PC4;
            end
            OPC_LUI: begin
                w_op1     = '0;
                w_rd_wren = 1'b1;
            end
            OPC_AUIPC: begin
                w_op1     = pc_i;
                w_rd_wren = 1'b1;
            end
            default: ;
        endcase
        w_rd_wren = w_rd_wren & w_rd_nz;
    end

    branch_cmp #(.WIDTH(XLEN)) u_branch_cmp (
        .i_a        (rs1_data_i),
        .i_b        (rs2_data_i),
        .i_unsigned (w_f3[1]),
        .o_eq       (w_eq),
        .o_lt       (w_lt)
    );

    always_comb begin
        case (w_f3)
            F3_BEQ:            w_taken = w_eq;
            F3_BNE:            w_taken = !w_eq;
            F3_BLT, F3_BLTU:   w_taken = w_lt;
            F3_BGE, F3_BGEU:   w_taken = !w_lt;
            default:           w_taken = 1'b0;
        endcase
    end

    always_comb begin
        case (w_alu_op)
            ALU_SUB:  w_alu_raw = w_op1 - w_op2;
            ALU_SLL:  w_alu_raw = w_op1 << w_op2[4:0];
            ALU_SLT:  w_alu_raw = {{(XLEN-1){1'b0}}, $signed(w_op1) < $signed(w_op2)};
            ALU_SLTU: w_alu_raw = {{(XLEN-1){1'b0}}, w_op1 < w_op2};
            ALU_XOR:  w_alu_raw = w_op1 ^ w_op2;
            ALU_SRL:  w_alu_raw = w_op1 >> w_op2[4:0];
            ALU_SRA:  w_alu_raw = $unsigned($signed(w_op1) >>> w_op2[4:0]);
            ALU_OR:   w_alu_raw = w_op1 | w_op2;
            ALU_AND:  w_alu_raw = w_op1 & w_op2;
            default:  w_alu_raw = w_op1 + w_op2;
        endcase
        w_alu_res = w_is_jalr ? {w_alu_raw[XLEN-1:1], 1'b0} : w_alu_raw;
    end

`ifdef RV32I_ILLEGAL_DET_EN
    logic w_illegal;

    always_comb begin
        case (w_opcode)
            OPC_R:      w_illegal = !((w_f7 == F7_BASE) ||
                                      ((w_f7 == F7_ALT) && ((w_f3 == F3_ADD) || (w_f3 == F3_SR))));
            OPC_BRANCH: w_illegal = (w_f3 == 3'b010) || (w_f3 == 3'b011);
            OPC_I, OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC:
                        w_illegal = 1'b0;
            default:    w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) illegal_o <= 1'b0;
        else       illegal_o <= w_illegal;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alu_result_o <= '0;
            pc_sel_o     <= 1'b0;
            rd_wren_o    <= 1'b0;
            mem_wren_o   <= 1'b0;
            wb_sel_o     <= '0;
            pc_plus4_o   <= '0;
        end else begin
            alu_result_o <= w_alu_res;
            pc_sel_o     <= w_is_jump | (w_is_branch & w_taken);
            rd_wren_o    <= w_rd_wren;
            mem_wren_o   <= w_mem_wren;
            wb_sel_o     <= w_wb_sel;
            pc_plus4_o   <= pc_i + XLEN'(4);
        end
    end

endmodule

// File: tb/tb_rv32i_exec_ctrl.sv
// Self-checking bench: directed cases plus random instructions against a behavioural model.
module tb_rv32i_exec_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] inst_i, pc_i, rs1_data_i, rs2_data_i, imm_i;
    logic [31:0] alu_result_o, pc_plus4_o;
    logic        pc_sel_o, rd_wren_o, mem_wren_o;
    logic [1:0]  wb_sel_o;
`ifdef RV32I_ILLEGAL_DET_EN
    logic        illegal_o;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk_i = ~clk_i;

    rv32i_exec_ctrl #(.XLEN(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .inst_i       (inst_i),
        .pc_i         (pc_i),
        .rs1_data_i   (rs1_data_i),
        .rs2_data_i   (rs2_data_i),
        .imm_i        (imm_i),
        .alu_result_o (alu_result_o),
        .pc_sel_o     (pc_sel_o),
        .rd_wren_o    (rd_wren_o),
        .mem_wren_o   (mem_wren_o),
        .wb_sel_o     (wb_sel_o),
`ifdef RV32I_ILLEGAL_DET_EN
        .illegal_o    (illegal_o),
`endif
        .pc_plus4_o   (pc_plus4_o)
    );

    typedef struct packed {
        logic [31:0] res;
        logic        pc_sel;
        logic        rd_wren;
        logic        mem_wren;
        logic [1:0]  wb_sel;
        logic [31:0] pc4;
        logic        illegal;
    } exp_t;

    localparam logic [6:0] R = 7'h33, I = 7'h13, LD = 7'h03, ST = 7'h23, BR = 7'h63;
    localparam logic [6:0] JAL = 7'h6F, JALR = 7'h67, LUI = 7'h37, AUIPC = 7'h17;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
        return {f7, 5'd2, 5'd1, f3, rd, op};
    endfunction

    // Reference: instruction semantics straight from the ISA description.
    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc,
                                   input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        exp_t e;
        logic [6:0] op = inst[6:0];
        logic [2:0] f3 = inst[14:12];
        logic [6:0] f7 = inst[31:25];
        logic [31:0] y;
        logic writes;
        e = '0;
        e.pc4 = pc + 32'd4;
        writes = 1'b0;
        case (op)
            R, I: begin
                y = (op == R) ? b : imm;
                case (f3)
                    3'd0: e.res = (op == R && inst[30]) ? a - y : a + y;
                    3'd1: e.res = a << y[4:0];
                    3'd2: e.res = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
                    3'd3: e.res = (a < y) ? 32'd1 : 32'd0;
                    3'd4: e.res = a ^ y;
                    3'd5: e.res = inst[30] ? 32'($signed(a) >>> y[4:0]) : a >> y[4:0];
                    3'd6: e.res = a | y;
                    default: e.res = a & y;
                endcase
                writes = 1'b1;
                if (op == R)
                    e.illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            end
            LD:    begin e.res = a + imm; writes = 1'b1; e.wb_sel = 2'b10; end
            ST:    begin e.res = a + imm; e.mem_wren = 1'b1; end
            BR: begin
                e.res = pc + imm;
                case (f3)
                    3'd0: e.pc_sel = (a == b);
                    3'd1: e.pc_sel = (a != b);
                    3'd4: e.pc_sel = ($signed(a) < $signed(b));
                    3'd5: e.pc_sel = ($signed(a) >= $signed(b));
                    3'd6: e.pc_sel = (a < b);
                    3'd7: e.pc_sel = (a >= b);
                    default: begin e.pc_sel = 1'b0; e.illegal = 1'b1; end
                endcase
            end
            JAL:   begin e.res = pc + imm; e.pc_sel = 1'b1; writes = 1'b1; e.wb_sel = 2'b01; end
            JALR:  begin e.res = (a + imm) & ~32'd1; e.pc_sel = 1'b1; writes = 1'b1; e.wb_sel = 2'b01; end
            LUI:   begin e.res = imm; writes = 1'b1; end
            AUIPC: begin e.res = pc + imm; writes = 1'b1; end
            default: begin e.res = a + imm; e.illegal = 1'b1; end
        endcase
        e.rd_wren = writes && (inst[11:7] != 5'd0);
        return e;
    endfunction

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        inst_i = inst; pc_i = pc; rs1_data_i = a; rs2_data_i = b; imm_i = imm;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_model(input string tag);
        exp_t e;
        e = model(inst_i, pc_i, rs1_data_i, rs2_data_i, imm_i);
        chk({tag, ".res"},   alu_result_o, e.res);
        chk({tag, ".pcsel"}, 32'(pc_sel_o), 32'(e.pc_sel));
        chk({tag, ".rdwe"},  32'(rd_wren_o), 32'(e.rd_wren));
        chk({tag, ".memwe"}, 32'(mem_wren_o), 32'(e.mem_wren));
        chk({tag, ".wbsel"}, 32'(wb_sel_o), 32'(e.wb_sel));
        chk({tag, ".pc4"},   pc_plus4_o, e.pc4);
`ifdef RV32I_ILLEGAL_DET_EN
        chk({tag, ".ill"},   32'(illegal_o), 32'(e.illegal));
`endif
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".res"},   alu_result_o, 32'd0);
        chk({tag, ".ctl"},   32'({pc_sel_o, rd_wren_o, mem_wren_o, wb_sel_o}), 32'd0);
        chk({tag, ".pc4"},   pc_plus4_o, 32'd0);
`ifdef RV32I_ILLEGAL_DET_EN
        chk({tag, ".ill"},   32'(illegal_o), 32'd0);
`endif
    endtask

    logic [6:0] ops [9] = '{R, I, LD, ST, BR, JAL, JALR, LUI, AUIPC};

    initial begin
        logic [31:0] inst, a, b;
        logic [6:0]  f7, op;
        logic [4:0]  rd;

        rst_i = 1'b1;
        drive(enc(7'h00, 3'd0, 5'd1, R), 32'h200, 32'h11, 32'h22, 32'h5);
        chk_zero("rst1");
        drive(enc(7'h00, 3'd0, 5'd1, R), 32'h200, 32'h11, 32'h22, 32'h5);
        chk_zero("rst2");
        rst_i = 1'b0;
        drive(enc(7'h00, 3'd0, 5'd1, R), 32'h200, 32'h11, 32'h22, 32'h5);
        chk("rst_rel.res", alu_result_o, 32'h33);
        chk("rst_rel.rdwe", 32'(rd_wren_o), 32'd1);
        chk("rst_rel.pc4", pc_plus4_o, 32'h204);

        drive(enc(7'h20, 3'd0, 5'd5, R), 32'h0, 32'h5, 32'h7, 32'h0);
        chk("sub.res", alu_result_o, 32'hFFFF_FFFE);
        chk("sub.ctl", 32'({rd_wren_o, wb_sel_o, pc_sel_o}), 32'b1000);
        chk_model("sub");

        drive(enc(7'h20, 3'd5, 5'd3, I), 32'h0, 32'h8000_0000, 32'h0, 32'd4);
        chk("srai.res", alu_result_o, 32'hF800_0000);
        drive(enc(7'h00, 3'd3, 5'd3, R), 32'h0, 32'h1, 32'hFFFF_FFFF, 32'h0);
        chk("sltu.res", alu_result_o, 32'd1);
        drive(enc(7'h00, 3'd2, 5'd3, R), 32'h0, 32'h1, 32'hFFFF_FFFF, 32'h0);
        chk("slt.res", alu_result_o, 32'd0);
        drive(enc(7'h20, 3'd0, 5'd3, I), 32'h0, 32'h10, 32'h0, 32'h3);
        chk("addi_b30.res", alu_result_o, 32'h13);

        drive(enc(7'h00, 3'd4, 5'd5, BR), 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20);
        chk("blt.pcsel", 32'(pc_sel_o), 32'd1);
        chk("blt.res", alu_result_o, 32'h120);
        chk("blt.rdwe", 32'(rd_wren_o), 32'd0);
        drive(enc(7'h00, 3'd6, 5'd5, BR), 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20);
        chk("bltu.pcsel", 32'(pc_sel_o), 32'd0);
        chk("bltu.rdwe", 32'(rd_wren_o), 32'd0);

        drive(enc(7'h00, 3'd0, 5'd1, JAL), 32'h40, 32'h0, 32'h0, 32'h8);
        chk("jal.res", alu_result_o, 32'h48);
        chk("jal.pc4", pc_plus4_o, 32'h44);
        chk("jal.wbsel", 32'(wb_sel_o), 32'd1);
        chk("jal.pcsel", 32'(pc_sel_o), 32'd1);
        drive(enc(7'h00, 3'd0, 5'd1, JALR), 32'h40, 32'h103, 32'h0, 32'h0);
        chk("jalr.res", alu_result_o, 32'h102);

        drive(enc(7'h00, 3'd2, 5'd4, ST), 32'h0, 32'h10, 32'h55, 32'h8);
        chk("sw.ctl", 32'({mem_wren_o, rd_wren_o}), 32'b10);
        drive(enc(7'h00, 3'd2, 5'd4, LD), 32'h0, 32'h10, 32'h0, 32'h4);
        chk("lw.res", alu_result_o, 32'h14);
        chk("lw.wbsel", 32'(wb_sel_o), 32'd2);
        drive(enc(7'h00, 3'd0, 5'd0, I), 32'h0, 32'h0, 32'h0, 32'h5);
        chk("addi_x0.rdwe", 32'(rd_wren_o), 32'd0);
        drive(enc(7'h00, 3'd0, 5'd6, 7'h7F), 32'h80, 32'h10, 32'h20, 32'h3);
        chk("nop.res", alu_result_o, 32'h13);
        chk("nop.ctl", 32'({pc_sel_o, rd_wren_o, mem_wren_o, wb_sel_o}), 32'd0);
        chk_model("nop");

        for (int i = 0; i < 400; i++) begin
            op = ($urandom_range(9) == 9) ? 7'($urandom) : ops[$urandom_range(8)];
            case ($urandom_range(3))
                0, 1:    f7 = 7'h00;
                2:       f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            rd = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
            inst = {f7, 10'($urandom), 3'($urandom), rd, op};
            a = ($urandom_range(3) == 0) ? 32'($urandom_range(16)) : $urandom;
            b = ($urandom_range(3) == 0) ? a : $urandom;
            if (i == 200) begin
                rst_i = 1'b1;
                drive(inst, $urandom, a, b, $urandom);
                chk_zero("rst_mid");
                rst_i = 1'b0;
            end
            drive(inst, $urandom, a, b, ($urandom_range(1) == 1) ? 32'($signed(12'($urandom))) : $urandom);
            chk_model("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
